// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_pkg
//  Description : Shared widths, ALU mode encodings, latency classes and the
//                controller state type for the ALU request controller.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_ctrl_pkg;

   // Requester / datapath geometry
   localparam int unsigned NUM_REQ  = 2;
   localparam int unsigned ID_W     = 1;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned RES_W    = 64;
   localparam int unsigned MODE_W   = 4;
   localparam int unsigned FLAG_W   = 3;
   localparam int unsigned STAT_W   = 5;   // {CF,OF,SF,PF,ZF}
   localparam int unsigned CNT_W    = 3;

   // Cycles the ALU needs before its result may be sampled
   localparam logic [CNT_W-1:0] LAT_COMB = 3'd1;
   localparam logic [CNT_W-1:0] LAT_MUL  = 3'd3;
   localparam logic [CNT_W-1:0] LAT_FP   = 3'd5;

   // ALU operation encodings (all 16 values of the mode field)
   typedef enum logic [MODE_W-1:0] {
      MODE_AND  = 4'b0000,
      MODE_OR   = 4'b0001,
      MODE_XOR  = 4'b0010,
      MODE_NOT  = 4'b0011,
      MODE_SHL  = 4'b0100,
      MODE_SHR  = 4'b0101,
      MODE_SAR  = 4'b0110,
      MODE_ROT  = 4'b0111,
      MODE_ADD  = 4'b1000,
      MODE_SUB  = 4'b1001,
      MODE_MUL  = 4'b1010,
      MODE_MISC = 4'b1011,
      MODE_FADD = 4'b1100,
      MODE_FSUB = 4'b1101,
      MODE_FMUL = 4'b1110,
      MODE_FDIV = 4'b1111
   } alu_mode_e;

   // Controller sequencing states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } ctrl_state_e;

   // Latency class of a mode. MODE_MISC is combinational whatever its flag
   // field says, so the flag field is deliberately not an input here.
   function automatic logic [CNT_W-1:0] mode_latency(input logic [MODE_W-1:0] mode);
      logic [CNT_W-1:0] lat;
      lat = LAT_COMB;
      if (mode == MODE_MUL) begin
         lat = LAT_MUL;
      end else if (mode[3:2] == 2'b11) begin
         lat = LAT_FP;
      end
      return lat;
   endfunction

   // Only add and subtract produce meaningful status flags
   function automatic logic mode_has_flags(input logic [MODE_W-1:0] mode);
      return (mode == MODE_ADD) || (mode == MODE_SUB);
   endfunction

endpackage : alu_ctrl_pkg
`default_nettype wire

// File: rtl/alu_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rr_arb
//  Description : Two-way round-robin arbiter. A lone valid requester wins;
//                on a tie the requester not granted last wins. After reset
//                requester 0 wins the first tie.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_rr_arb
   import alu_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,        // asynchronous, active low
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic               advance_i,  // grant is being consumed this cycle
   output logic [ID_W-1:0]    grant_o
);

   // Requester served by the most recent accepted grant
   logic [ID_W-1:0] last_q;

   // Pick the single valid requester, or on a tie the one not served last
   always_comb begin
      grant_o = '0;
      case (valid_i)
         2'b01:   grant_o = 1'b0;
         2'b10:   grant_o = 1'b1;
         2'b11:   grant_o = ~last_q;
         default: grant_o = '0;
      endcase
   end

   // Remember who was served; reset value makes requester 0 win the first tie
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= 1'b1;
      end else if (advance_i) begin
         last_q <= grant_o;
      end
   end

endmodule : alu_rr_arb
`default_nettype wire

// File: rtl/alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl
//  Description : Shares one multi-latency ALU between two requesters.
//                Accepts one op at a time in IDLE, drives the ALU from ISSUE
//                until the result is captured, waits the mode's latency and
//                holds the response until it is taken.
//  Options     : ALU_CTRL_FLAGS_EN - when defined, rsp_flags returns the ALU
//                status flags for add/sub; otherwise rsp_flags is tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_ctrl
   import alu_ctrl_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,          // asynchronous, active low
   // Requester side
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]  req_a,
   input  logic [NUM_REQ*DATA_W-1:0]  req_b,
   input  logic [NUM_REQ*DATA_W-1:0]  req_ahigh,
   input  logic [NUM_REQ*MODE_W-1:0]  req_mode,
   input  logic [NUM_REQ*FLAG_W-1:0]  req_flag,
   // ALU side
   output logic [DATA_W-1:0]          alu_a,
   output logic [DATA_W-1:0]          alu_b,
   output logic [DATA_W-1:0]          alu_ahigh,
   output logic [MODE_W-1:0]          alu_mode,
   output logic [FLAG_W-1:0]          alu_flag,
   input  logic [RES_W-1:0]           alu_out,
   input  logic [STAT_W-1:0]          alu_flag_out,
   // Response side
   output logic                       rsp_valid,
   output logic [ID_W-1:0]            rsp_id,
   output logic [RES_W-1:0]           rsp_data,
   input  logic                       rsp_ready,
   output logic [STAT_W-1:0]          rsp_flags
);

   ctrl_state_e        state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [ID_W-1:0]    id_q;

   logic [DATA_W-1:0]  alu_a_q;
   logic [DATA_W-1:0]  alu_b_q;
   logic [DATA_W-1:0]  alu_ahigh_q;
   logic [MODE_W-1:0]  alu_mode_q;
   logic [FLAG_W-1:0]  alu_flag_q;

   logic               rsp_valid_q;
   logic [ID_W-1:0]    rsp_id_q;
   logic [RES_W-1:0]   rsp_data_q;

   logic [ID_W-1:0]    gnt;
   logic               accept;
   logic               capture;

   logic [DATA_W-1:0]  sel_a;
   logic [DATA_W-1:0]  sel_b;
   logic [DATA_W-1:0]  sel_ahigh;
   logic [MODE_W-1:0]  sel_mode;
   logic [FLAG_W-1:0]  sel_flag;

   // An op is taken only from IDLE; the cycle after a response is always IDLE
   assign accept  = (state_q == ST_IDLE) && (|req_valid);
   assign capture = (state_q == ST_WAIT) && (cnt_q == '0);

   alu_rr_arb u_arb (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (req_valid),
      .advance_i (accept),
      .grant_o   (gnt)
   );

   // Accept strobe for the granted requester; held low while reset is active
   always_comb begin
      req_ready = '0;
      if (accept && rst) begin
         req_ready[gnt] = 1'b1;
      end
   end

   // Route the granted requester's operand lane
   always_comb begin
      sel_a     = '0;
      sel_b     = '0;
      sel_ahigh = '0;
      sel_mode  = '0;
      sel_flag  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt == ID_W'(i)) begin
            sel_a     = req_a[i*DATA_W +: DATA_W];
            sel_b     = req_b[i*DATA_W +: DATA_W];
            sel_ahigh = req_ahigh[i*DATA_W +: DATA_W];
            sel_mode  = req_mode[i*MODE_W +: MODE_W];
            sel_flag  = req_flag[i*FLAG_W +: FLAG_W];
         end
      end
   end

   // Sequencer: latch op, load latency, count down, capture, hold response
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         id_q        <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_ahigh_q <= '0;
         alu_mode_q  <= '0;
         alu_flag_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  id_q        <= gnt;
                  alu_a_q     <= sel_a;
                  alu_b_q     <= sel_b;
                  alu_ahigh_q <= sel_ahigh;
                  alu_mode_q  <= sel_mode;
                  alu_flag_q  <= sel_flag;
                  state_q     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt_q   <= mode_latency(alu_mode_q);
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (capture) begin
                  rsp_data_q  <= alu_out;
                  rsp_id_q    <= id_q;
                  rsp_valid_q <= 1'b1;
                  // The ALU is released once its result is sampled
                  alu_a_q     <= '0;
                  alu_b_q     <= '0;
                  alu_ahigh_q <= '0;
                  alu_mode_q  <= '0;
                  alu_flag_q  <= '0;
                  state_q     <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_ahigh = alu_ahigh_q;
   assign alu_mode  = alu_mode_q;
   assign alu_flag  = alu_flag_q;

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;

`ifdef ALU_CTRL_FLAGS_EN
   logic [STAT_W-1:0] rsp_flags_q;

   // Status flags travel with the result, but only for add/sub
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_flags_q <= '0;
      end else if (capture) begin
         rsp_flags_q <= mode_has_flags(alu_mode_q) ? alu_flag_out : '0;
      end
   end

   assign rsp_flags = rsp_flags_q;
`else
   // Flag return disabled: ALU status is not stored
   logic unused_alu_flag_out;
   assign unused_alu_flag_out = ^alu_flag_out;
   assign rsp_flags = '0;
`endif

endmodule : alu_ctrl
`default_nettype wire

// File: tb/tb_alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_ctrl
//  Description : Directed self-checking bench for alu_ctrl with a small
//                behavioural ALU. Honours ALU_CTRL_FLAGS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_a, req_b, req_ahigh;
   logic [7:0]  req_mode;
   logic [5:0]  req_flag;
   logic [31:0] alu_a, alu_b, alu_ahigh;
   logic [3:0]  alu_mode;
   logic [2:0]  alu_flag;
   logic [63:0] alu_out;
   logic [4:0]  alu_flag_out;
   logic        rsp_valid;
   logic        rsp_id;
   logic [63:0] rsp_data;
   logic        rsp_ready;
   logic [4:0]  rsp_flags;

   int n_checks = 0;
   int n_errors = 0;

`ifdef ALU_CTRL_FLAGS_EN
   localparam logic [4:0] EXP_ZF = 5'b00001;
`else
   localparam logic [4:0] EXP_ZF = 5'b00000;
`endif

   always #5 clk = ~clk;

   alu_ctrl u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_ahigh    (req_ahigh),
      .req_mode     (req_mode),
      .req_flag     (req_flag),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_ahigh    (alu_ahigh),
      .alu_mode     (alu_mode),
      .alu_flag     (alu_flag),
      .alu_out      (alu_out),
      .alu_flag_out (alu_flag_out),
      .rsp_valid    (rsp_valid),
      .rsp_id       (rsp_id),
      .rsp_data     (rsp_data),
      .rsp_ready    (rsp_ready),
      .rsp_flags    (rsp_flags)
   );

   // Behavioural ALU: add, sub, mul, FP-class xor with the high word, else pass A
   always_comb begin
      case (alu_mode)
         4'b1000: alu_out = {32'b0, alu_a} + {32'b0, alu_b};
         4'b1001: alu_out = {32'b0, alu_a} - {32'b0, alu_b};
         4'b1010: alu_out = {32'b0, alu_a} * {32'b0, alu_b};
         4'b1100, 4'b1101, 4'b1110, 4'b1111:
                  alu_out = {alu_ahigh, alu_a} ^ {32'b0, alu_b};
         default: alu_out = {32'b0, alu_a};
      endcase
      alu_flag_out = {2'b00, alu_out[63], 1'b0, (alu_out == 64'd0)};
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int id, input logic [3:0] m, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] h, input logic [2:0] f);
      req_mode[id*4 +: 4]    = m;
      req_a[id*32 +: 32]     = a;
      req_b[id*32 +: 32]     = b;
      req_ahigh[id*32 +: 32] = h;
      req_flag[id*3 +: 3]    = f;
   endtask

   // Issue one op (caller is 1ns after a rising edge, DUT idle) and follow it
   task automatic run_op(input string tag, input logic [1:0] vmask, input int gid,
                         input int lat, input logic [63:0] exp_data,
                         input logic [4:0] exp_flags, input int hold, input bit early_rdy);
      logic [31:0] ea, eb, eh;
      logic [3:0]  em;
      logic [2:0]  ef;
      logic [63:0] d0;
      bit          stable, got, held;
      int          seen;
      ea = req_a[gid*32 +: 32];
      eb = req_b[gid*32 +: 32];
      eh = req_ahigh[gid*32 +: 32];
      em = req_mode[gid*4 +: 4];
      ef = req_flag[gid*3 +: 3];
      req_valid = vmask;
      rsp_ready = early_rdy;
      #1;
      check({tag, "/ready"}, 64'(req_ready), (gid == 1) ? 64'd2 : 64'd1);
      @(posedge clk); #1;
      stable = 1'b1;
      got    = 1'b0;
      seen   = 0;
      for (int k = 1; k <= 20 && !got; k++) begin
         if (alu_a !== ea || alu_b !== eb || alu_ahigh !== eh || alu_mode !== em ||
             alu_flag !== ef || req_ready !== 2'b00 || rsp_valid !== 1'b0)
            stable = 1'b0;
         @(posedge clk); #1;
         if (rsp_valid === 1'b1) begin
            got  = 1'b1;
            seen = k;
         end
      end
      check({tag, "/latency"}, 64'(seen), 64'(2 + lat));
      check({tag, "/alu_stable"}, 64'(stable), 64'd1);
      check({tag, "/rsp_id"}, 64'(rsp_id), 64'(gid));
      check({tag, "/rsp_data"}, rsp_data, exp_data);
      check({tag, "/rsp_flags"}, 64'(rsp_flags), 64'(exp_flags));
      check({tag, "/alu_released"}, 64'(alu_a), 64'd0);
      if (hold > 0) begin
         d0   = rsp_data;
         held = 1'b1;
         for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_id !== 1'(gid) ||
                rsp_flags !== exp_flags || req_ready !== 2'b00 || alu_a !== 32'd0)
               held = 1'b0;
         end
         check({tag, "/rsp_held"}, 64'(held), 64'd1);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check({tag, "/rsp_done"}, 64'(rsp_valid), 64'd0);
      // The handshake edge must not also accept a new op
      check({tag, "/no_same_cycle_accept"}, 64'(alu_a), 64'd0);
      req_valid = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit quiet;
      rst       = 1'b0;
      req_valid = 2'b11;
      rsp_ready = 1'b0;
      req_a = '0; req_b = '0; req_ahigh = '0; req_mode = '0; req_flag = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset/req_ready", 64'(req_ready), 64'd0);
      check("reset/rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset/alu_a", 64'(alu_a), 64'd0);
      check("reset/rsp_data", rsp_data, 64'd0);
      rst = 1'b1;

      // Round robin from reset: 0,1,0,1 with both requesters always valid
      set_req(0, 4'b1000, 32'd5, 32'd7, 32'd0, 3'd0);
      set_req(1, 4'b1010, 32'd3, 32'd4, 32'd0, 3'd0);
      run_op("rr0_add", 2'b11, 0, 1, 64'd12, 5'd0, 0, 1'b0);
      run_op("rr1_mul", 2'b11, 1, 3, 64'd12, 5'd0, 0, 1'b0);
      set_req(0, 4'b1000, 32'd100, 32'd23, 32'd0, 3'd0);
      set_req(1, 4'b1010, 32'd6, 32'd7, 32'd0, 3'd0);
      run_op("rr2_add", 2'b11, 0, 1, 64'd123, 5'd0, 0, 1'b0);
      run_op("rr3_mul", 2'b11, 1, 3, 64'd42, 5'd0, 0, 1'b0);

      // FP latency class, response held ten cycles without rsp_ready
      set_req(1, 4'b1100, 32'd2, 32'd3, 32'd1, 3'd0);
      run_op("fp_hold", 2'b10, 1, 5, 64'h0000_0001_0000_0001, 5'd0, 10, 1'b0);

      // Subtract to zero: ZF returned only when flags are enabled; rsp_ready early
      set_req(0, 4'b1001, 32'd9, 32'd9, 32'd0, 3'd0);
      run_op("sub_zero", 2'b01, 0, 1, 64'd0, EXP_ZF, 0, 1'b1);

      // Multiply to zero: ALU raises ZF but mul never returns flags
      set_req(0, 4'b1010, 32'd0, 32'd5, 32'd0, 3'd0);
      run_op("mul_zero", 2'b01, 0, 3, 64'd0, 5'd0, 0, 1'b0);

      // Mode 1011 with flag 10 is combinational and forwarded as-is
      set_req(1, 4'b1011, 32'h0000_DEAD, 32'd1, 32'd0, 3'b010);
      run_op("misc_fwd", 2'b10, 1, 1, 64'h0000_0000_0000_DEAD, 5'd0, 0, 1'b0);

      // Reset in the middle of an FP op
      set_req(0, 4'b1110, 32'd4, 32'd1, 32'd0, 3'd0);
      req_valid = 2'b01;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("midreset/alu_a", 64'(alu_a), 64'd0);
      check("midreset/alu_mode", 64'(alu_mode), 64'd0);
      check("midreset/req_ready", 64'(req_ready), 64'd0);
      check("midreset/rsp_data", rsp_data, 64'd0);
      check("midreset/rsp_id", 64'(rsp_id), 64'd0);
      @(posedge clk); #1;
      rst       = 1'b1;
      req_valid = 2'b00;
      quiet     = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (rsp_valid !== 1'b0 || alu_a !== 32'd0) quiet = 1'b0;
      end
      check("midreset/no_response", 64'(quiet), 64'd1);

      // Tie after reset goes to requester 0 again
      set_req(1, 4'b1000, 32'd1, 32'd1, 32'd0, 3'd0);
      run_op("post_reset_tie", 2'b11, 0, 5, 64'd5, 5'd0, 0, 1'b0);
      run_op("post_reset_next", 2'b11, 1, 1, 64'd2, 5'd0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_alu_ctrl
`default_nettype wire

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port req_valid  input  2  per-requester operation request (bit i = requester i).
REQ-004 SHALL have port req_ready  output  2  per-requester accept strobe.
REQ-005 SHALL have ports req_a, req_b, req_ahigh  input  64 each  packed operands {req1, req0}, 32b per requester.
REQ-006 SHALL have ports req_mode  input  8  and req_flag  input  6  packed {req1, req0}, 4b mode and 3b flag per requester.
REQ-007 SHALL have ports alu_a, alu_b, alu_ahigh  output  32 each, alu_mode  output  4, alu_flag  output  3  driving the ALU.
REQ-008 SHALL have ports alu_out  input  64 and alu_flag_out  input  5  ALU results.
REQ-009 SHALL have ports rsp_valid  output  1, rsp_id  output  1, rsp_data  output  64, rsp_ready  input  1  result handshake.
REQ-010 SHALL have port rsp_flags  output  5  {CF,OF,SF,PF,ZF} (see Configuration).

Function
REQ-011 SHALL run FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-012 In IDLE with any req_valid high, SHALL pulse req_ready of the granted requester combinationally for that cycle, latch its operands/mode/flag, go to ISSUE.
REQ-013 Grant SHALL be round-robin: single valid wins; both valid -> requester not granted last; after reset requester 0 wins the first tie.
REQ-014 Latched operands SHALL drive alu_* from ISSUE until capture, held stable; alu_* outputs zero in IDLE.
REQ-015 Latency counter SHALL load in ISSUE: modes 0000-1001 and 1011 -> LAT_COMB=1; 1010 -> LAT_MUL=3; 1100-1111 -> LAT_FP=5.
REQ-016 WAIT SHALL decrement per cycle; at count 0 capture alu_out into rsp_data, granted id into rsp_id, go to RESP.
REQ-017 Op accepted at edge N (LAT_COMB) SHALL assert rsp_valid at edge N+3; general: N+2+LAT.
REQ-018 RESP SHALL hold rsp_valid, rsp_id, rsp_data, rsp_flags stable until rsp_ready high at an edge, then return to IDLE.
REQ-019 No request SHALL be accepted outside IDLE; req_ready SHALL be 0 in ISSUE/WAIT/RESP.
REQ-020 Return to IDLE and new acceptance SHALL NOT occur in the same cycle (one idle cycle minimum between ops).
REQ-021 rsp_ready while not in RESP SHALL be ignored.
REQ-022 Mode 1011 with flag[1:0]=10 SHALL be treated as LAT_COMB and forwarded unchanged.

Reset
REQ-023 rst low SHALL immediately force IDLE, counter 0, round-robin pointer to favour requester 0, and all outputs 0, including mid-operation; the in-flight op is dropped with no response.
REQ-024 First acceptance SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-025 Macro ALU_CTRL_FLAGS_EN defined: rsp_flags SHALL capture alu_flag_out with rsp_data for modes 1000/1001, and 0 for other modes.
REQ-026 Macro undefined: rsp_flags SHALL be tied to 0 and no flag register instantiated.

Structure
REQ-027 Package alu_ctrl_pkg SHALL hold mode encodings (16 values), LAT_COMB/LAT_MUL/LAT_FP, and FSM state enum typedef.
REQ-028 Round-robin grant SHALL be sub-module alu_rr_arb (inputs valid[1:0], advance; output grant index); all else in alu_ctrl.

Verification
REQ-029 Req0 mode 1000 A=5 B=7, ALU model returns 12 flags 00000 -> rsp_valid at edge N+3, rsp_id=0, rsp_data=64'd12.
REQ-030 Both valid from reset, back-to-back ops -> grants 0,1,0,1; rsp_id sequence matches.
REQ-031 Req1 mode 1010 A=3 B=4 -> rsp_data=12 at edge N+5; mode 1100 -> rsp at N+7; alu_* stable throughout.
REQ-032 rsp_ready held low 10 cycles in RESP -> rsp outputs unchanged, req_ready stays 0, no new accept.
REQ-033 rst asserted in WAIT of LAT_FP op -> all outputs 0 at once, no response after release; next op accepted normally.
REQ-034 ALU_CTRL_FLAGS_EN defined, mode 1001 A=B=9 -> rsp_flags ZF=1; undefined -> rsp_flags=0.
